// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit path.
//   tx_state_e : frame FSM state encoding
//   PAR_*      : parity_type encodings
//   STOP_*     : stop_bits encodings
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;
    localparam logic STOP_ONE = 1'b0;
    localparam logic STOP_TWO = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// LSB-first payload serializer for the UART transmitter.
//   CLK, RST  : bit clock, async active-low reset
//   load      : capture p_data and restart the bit counter
//   ser_en    : consume the current bit (shift right, count)
//   p_data    : parallel payload
//   ser_data  : bit that the next ser_en will consume
//   ser_done  : set once the last payload bit has been consumed
module uart_tx_serializer #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  load,
    input  logic                  ser_en,
    input  logic [DATA_WIDTH-1:0] p_data,
    output logic                  ser_data,
    output logic                  ser_done
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] shift_q;
    logic [CNT_W-1:0]      cnt_q;

    // Counter tracks which bit sits at shift_q[0]; ser_done marks the
    // consumption of bit DATA_WIDTH-1, so it is high during the last DATA cycle.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shift_q  <= '0;
            cnt_q    <= '0;
            ser_done <= 1'b0;
        end else if (load) begin
            shift_q  <= p_data;
            cnt_q    <= '0;
            ser_done <= 1'b0;
        end else if (ser_en) begin
            shift_q  <= {1'b0, shift_q[DATA_WIDTH-1:1]};
            ser_done <= (cnt_q == LAST_BIT);
            cnt_q    <= (cnt_q == LAST_BIT) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    assign ser_data = shift_q[0];

endmodule

// File: rtl/uart_tx_ctrl.sv
// Parametrised UART transmit engine: start bit, DATA_WIDTH data bits LSB
// first, optional even/odd parity, one or two stop bits, back-to-back frames.
//   CLK, RST       : TX bit clock, async active-low reset
//   P_DATA         : payload, captured on acceptance
//   Data_Valid     : send request (honoured in IDLE and the last stop cycle)
//   parity_enable  : insert parity bit
//   parity_type    : 0 even, 1 odd
//   stop_bits      : 0 one stop bit, 1 two stop bits
//   TX_OUT         : serial line, idles high
//   busy           : high while any frame bit is on TX_OUT
//   tx_done        : pulse during the final stop-bit cycle
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  parity_enable,
    input  logic                  parity_type,
    input  logic                  stop_bits,
    output logic                  TX_OUT,
    output logic                  busy,
    output logic                  tx_done
);

    tx_state_e state_q, state_d;

    logic par_en_q;
    logic par_bit_q;
    logic stop_q;
    logic stop_cnt_q;

    logic load;
    logic ser_en;
    logic ser_data;
    logic ser_done;
    logic accept;
    logic last_stop;
    logic tx_d;
    logic busy_d;
    logic done_d;

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_serializer (
        .CLK      (CLK),
        .RST      (RST),
        .load     (load),
        .ser_en   (ser_en),
        .p_data   (P_DATA),
        .ser_data (ser_data),
        .ser_done (ser_done)
    );

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus next-cycle line value; outputs are decoded from state_d
    // so they change on the same edge the FSM enters each state.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        load      = 1'b0;
        ser_en    = 1'b0;
        tx_d      = 1'b1;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        last_stop = (state_q == STOP) && ((stop_q == STOP_ONE) || stop_cnt_q);

        case (state_q)
            IDLE:    accept = Data_Valid;
            START:   state_d = DATA;
            DATA: begin
                if (ser_done) begin
                    state_d = par_en_q ? PARITY : STOP;
                end
            end
            PARITY:  state_d = STOP;
            STOP: begin
                if (last_stop) begin
                    accept  = Data_Valid;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            state_d = START;
            load    = 1'b1;
        end

        case (state_d)
            START: begin
                tx_d   = 1'b0;
                busy_d = 1'b1;
            end
            DATA: begin
                tx_d   = ser_data;
                busy_d = 1'b1;
                ser_en = 1'b1;
            end
            PARITY: begin
                tx_d   = par_bit_q;
                busy_d = 1'b1;
            end
            STOP: begin
                tx_d   = 1'b1;
                busy_d = 1'b1;
                // Next STOP cycle is final if it is the second, or if only one is configured
                done_d = (state_q == STOP) || (stop_q == STOP_ONE);
            end
            default: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
            end
        endcase
    end

    // Frame configuration and parity, frozen at acceptance
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop_q    <= STOP_ONE;
        end else if (accept) begin
            par_en_q  <= parity_enable;
            par_bit_q <= (parity_type == PAR_EVEN) ? (^P_DATA) : ~(^P_DATA);
            stop_q    <= stop_bits;
        end
    end

    // Marks the second stop cycle
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            stop_cnt_q <= 1'b0;
        end else begin
            stop_cnt_q <= (state_q == STOP) && (state_d == STOP);
        end
    end

    // Output registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            TX_OUT  <= 1'b1;
            busy    <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            TX_OUT  <= tx_d;
            busy    <= busy_d;
            tx_done <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl (DATA_WIDTH = 8).
// The driver pushes the expected per-cycle line/tx_done values after each
// acceptance edge; the monitor pops one entry per busy cycle on the falling edge.
module tb_uart_tx_ctrl;

    typedef struct packed {
        logic tx;
        logic done;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       parity_enable;
    logic       parity_type;
    logic       stop_bits;
    logic       TX_OUT;
    logic       busy;
    logic       tx_done;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    uart_tx_ctrl #(
        .DATA_WIDTH (8)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .P_DATA        (P_DATA),
        .Data_Valid    (Data_Valid),
        .parity_enable (parity_enable),
        .parity_type   (parity_type),
        .stop_bits     (stop_bits),
        .TX_OUT        (TX_OUT),
        .busy          (busy),
        .tx_done       (tx_done)
    );

    always #5 CLK = ~CLK;

    function automatic exp_t mk(input logic tx, input logic done);
        exp_t e;
        e.tx   = tx;
        e.done = done;
        return e;
    endfunction

    // par is the hand-computed parity bit for the vector
    task automatic push_frame(input logic [7:0] d, input logic pe,
                              input logic sb, input logic par);
        sb_q.push_back(mk(1'b0, 1'b0));
        for (int i = 0; i < 8; i++) sb_q.push_back(mk(d[i], 1'b0));
        if (pe) sb_q.push_back(mk(par, 1'b0));
        if (sb) sb_q.push_back(mk(1'b1, 1'b0));
        sb_q.push_back(mk(1'b1, 1'b1));
    endtask

    // Called just after a rising edge with the DUT idle
    task automatic start_frame(input logic [7:0] d, input logic pe, input logic pt,
                               input logic sb, input logic par);
        P_DATA        = d;
        parity_enable = pe;
        parity_type   = pt;
        stop_bits     = sb;
        Data_Valid    = 1'b1;
        @(posedge CLK);
        #1;
        Data_Valid = 1'b0;
        push_frame(d, pe, sb, par);
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 40; n++) begin
            if (sb_q.size() == 0) break;
            @(posedge CLK);
        end
        if (sb_q.size() != 0) begin
            $display("FAIL frame_timeout: %0d expected bits never appeared, required 0 pending", sb_q.size());
            $fatal(1, "frame timeout");
        end
        #1;
    endtask

    // Monitor: reset values, frame bits while busy, idle line otherwise
    always @(negedge CLK) begin
        exp_t e;
        if (!RST) begin
            sb_q.delete();
            checks++;
            if (TX_OUT !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) begin
                errors++;
                $display("FAIL reset_state: TX_OUT=%b busy=%b tx_done=%b, required 1 0 0 at %0t",
                         TX_OUT, busy, tx_done, $time);
            end
        end else if (busy === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_busy: busy=1 TX_OUT=%b with no frame pending, required busy=0 at %0t",
                         TX_OUT, $time);
            end else begin
                e = sb_q.pop_front();
                if (TX_OUT !== e.tx || tx_done !== e.done) begin
                    errors++;
                    $display("FAIL frame_bit: TX_OUT=%b tx_done=%b, required TX_OUT=%b tx_done=%b at %0t",
                             TX_OUT, tx_done, e.tx, e.done, $time);
                end
            end
        end else begin
            checks++;
            if (sb_q.size() != 0) begin
                errors++;
                $display("FAIL busy_gap: busy=%b with %0d bits pending, required busy=1 at %0t",
                         busy, sb_q.size(), $time);
            end else if (TX_OUT !== 1'b1 || tx_done !== 1'b0) begin
                errors++;
                $display("FAIL idle_line: TX_OUT=%b tx_done=%b, required 1 0 at %0t",
                         TX_OUT, tx_done, $time);
            end
        end
    end

    initial begin
        RST           = 1'b0;
        P_DATA        = 8'h00;
        Data_Valid    = 1'b0;
        parity_enable = 1'b0;
        parity_type   = 1'b0;
        stop_bits     = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;

        // 0xA5, no parity, one stop: 0,1,0,1,0,0,1,0,1,1
        start_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_idle();

        // 0xA5 even parity (bit 0), then odd parity (bit 1)
        start_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_idle();
        start_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b1);
        wait_idle();

        // 0x3C, two stop bits
        start_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_idle();

        // Back-to-back 0x01 then 0x80 with Data_Valid held high
        P_DATA        = 8'h01;
        parity_enable = 1'b0;
        parity_type   = 1'b0;
        stop_bits     = 1'b0;
        Data_Valid    = 1'b1;
        @(posedge CLK);
        #1;
        push_frame(8'h01, 1'b0, 1'b0, 1'b0);
        P_DATA = 8'h80;
        repeat (10) @(posedge CLK);
        #1;
        push_frame(8'h80, 1'b0, 1'b0, 1'b0);
        Data_Valid = 1'b0;
        wait_idle();

        // Mid-frame input changes and a stray Data_Valid are ignored
        start_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge CLK);
        #1;
        P_DATA        = 8'hFF;
        parity_type   = 1'b1;
        parity_enable = 1'b0;
        stop_bits     = 1'b1;
        Data_Valid    = 1'b1;
        @(posedge CLK);
        #1;
        Data_Valid = 1'b0;
        wait_idle();

        // Reset during data bit 4 of 0xA5 (a 0 on the line), then 0x55 odd parity, two stops
        start_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (5) @(posedge CLK);
        #3 RST = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;
        @(posedge CLK);
        #1;
        start_frame(8'h55, 1'b1, 1'b1, 1'b1, 1'b1);
        wait_idle();

        repeat (3) @(posedge CLK);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Complete parametrised UART transmit engine for the multi-clock system's UART path.
- Contains the FSM, data capture register, serializer, parity generator and output mux.
- Generalises the existing fixed-width transmit controller with configurable data width, runtime even/odd parity, 1 or 2 stop bits, back-to-back frames and a frame-done pulse.
- CLK is the TX bit clock (one frame bit per CLK cycle).

Parameters:
- DATA_WIDTH, 8, payload bits per frame (legal range 5..9).

Ports:
- CLK  input  1  TX bit clock.
- RST  input  1  asynchronous, active-low reset.
- P_DATA  input  DATA_WIDTH  parallel payload; sampled only when a frame is accepted.
- Data_Valid  input  1  request to send P_DATA.
- parity_enable  input  1  1 = insert parity bit.
- parity_type  input  1  0 = even, 1 = odd.
- stop_bits  input  1  0 = one stop bit, 1 = two stop bits.
- TX_OUT  output  1  serial line, idles high.
- busy  output  1  high for every cycle a frame bit (start..last stop) is on TX_OUT.
- tx_done  output  1  one-cycle pulse during the final stop-bit cycle.

Behaviour:
- Reset (RST low, async):
  - state = IDLE; TX_OUT = 1; busy = 0; tx_done = 0.
  - Capture register, shift register and bit counter cleared.
  - Reset mid-frame aborts the frame immediately; TX_OUT returns high with no glitch-low.
- Registered outputs:
  - TX_OUT, busy and tx_done are registered and decoded from next_state and the next bit value.
  - Each therefore changes on the same edge the FSM enters the corresponding state.
- States: IDLE, START, DATA, PARITY, STOP (package enum).
- Acceptance:
  - At an edge where state is IDLE and Data_Valid = 1, the block:
    - latches P_DATA, parity_enable, parity_type and stop_bits;
    - computes the parity bit: XOR-reduce of the data, inverted when parity_type = 1;
    - enters START.
  - Latency: the start bit (0) appears on TX_OUT, with busy = 1, in the cycle immediately after the accepting edge.
- Transitions:
  - START -> DATA after 1 cycle.
  - DATA transmits the latched data LSB first, one bit per cycle, for exactly DATA_WIDTH cycles. The bit counter runs 0..DATA_WIDTH-1; ser_done asserts at count DATA_WIDTH-1.
  - DATA with ser_done -> PARITY if the latched parity_enable = 1, else -> STOP.
  - PARITY drives the parity bit for 1 cycle -> STOP.
  - STOP drives 1 for 1 cycle, or 2 cycles when the latched stop_bits = 1 (internal stop counter).
- End of frame:
  - The last STOP cycle has tx_done = 1.
  - If Data_Valid = 1 in the last STOP cycle: new data is accepted and the FSM goes directly to START (zero idle gap; busy stays 1).
  - Otherwise the FSM goes to IDLE and busy drops.
- Frame length: 1 + DATA_WIDTH + P + S cycles, where P = parity_enable and S = 1 or 2.
- Mid-frame inputs:
  - Data_Valid outside IDLE and outside the last STOP cycle is ignored (no queuing).
  - Changes to P_DATA or any config input mid-frame have no effect.
- Illegal or unreachable state encodings -> IDLE with TX_OUT = 1.

Decomposition:
- Package uart_tx_pkg:
  - typedef enum logic [2:0] tx_state_e {IDLE, START, DATA, PARITY, STOP};
  - localparams PAR_EVEN = 1'b0, PAR_ODD = 1'b1, STOP_ONE = 1'b0, STOP_TWO = 1'b1.
- Sub-module uart_tx_serializer, parametrised by DATA_WIDTH:
  - load/shift register, bit counter and ser_done flag.
  - Inputs load, ser_en; outputs ser_data, ser_done.
- The top level holds the FSM, parity generation, stop counter and output registers.

Test Plan:
- DATA_WIDTH = 8, P_DATA = 0xA5, parity off, 1 stop: TX_OUT sequence 0,1,0,1,0,0,1,0,1,1 starting the cycle after acceptance; busy high 10 cycles; tx_done on cycle 10.
- 0xA5 with even parity, then odd parity: parity bit 0 then 1 after the 8 data bits; frame 11 cycles.
- 0x3C, parity off, stop_bits = 1: two stop-bit cycles; tx_done only on the second; frame 11 cycles.
- Data_Valid held high with 0x01 then 0x80: second start bit directly follows the first frame's stop bit; busy never drops between frames.
- Change P_DATA and parity_type during DATA: transmitted bits and parity match the values latched at acceptance.
- Assert RST low during bit 4 of DATA: TX_OUT = 1, busy = 0 asynchronously; after release, a new 0x55 frame transmits correctly.
